// File: rtl/aibcr3_dll_dlyctrl64.sv
// DLL delay-line controller: filters phase-detector votes into a 0..64 code,
// drives a 64-cell thermometer select and flags dither lock.
module aibcr3_dll_dlyctrl64 #(
  parameter int FILT_LEN    = 4,
  parameter int SETTLE      = 8,
  parameter int LOCK_DITHER = 3,
  parameter int INIT_CODE   = 32
) (
  input  logic        CLKIN,
  input  logic        RSTb,
  input  logic        en,
  input  logic        pd_up,
  input  logic        pd_dn,
  input  logic        ovr_en,
  input  logic [6:0]  ovr_code,
  output logic [63:0] bk,
  output logic [6:0]  code,
  output logic        lock,
  output logic        at_min,
  output logic        at_max
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_TRACK, ST_LOCKED} state_t;

  localparam logic [6:0]        CODE_MAX = 7'd64;
  localparam logic [6:0]        INIT_W   = 7'(INIT_CODE);
  localparam logic [4:0]        SETTLE_W = 5'(SETTLE);
  localparam logic [2:0]        REV_MAX  = 3'(LOCK_DITHER);
  localparam logic signed [4:0] FILT_P   = 5'(FILT_LEN);
  localparam logic signed [4:0] FILT_N   = -FILT_P;
  localparam logic [63:0]       BK_INIT  = (INIT_CODE >= 64) ? {64{1'b1}}
                                         : ((64'd1 << INIT_CODE) - 64'd1);
  localparam logic [1:0]        DIR_NONE = 2'd0;
  localparam logic [1:0]        DIR_UP   = 2'd1;
  localparam logic [1:0]        DIR_DN   = 2'd2;

  // Reset asserts asynchronously, releases two CLKIN edges later.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge CLKIN or negedge RSTb) begin
    if (!RSTb) rst_sync_q <= 2'b00;
    else       rst_sync_q <= rst_sync_d;
  end

  state_t             state_q, state_d;
  logic [6:0]         code_q, code_d;
  logic [63:0]        bk_q, bk_d;
  logic               lock_q, lock_d;
  logic signed [4:0]  filt_q, filt_d;
  logic [4:0]         settle_q, settle_d;
  logic [2:0]         rev_q, rev_d;
  logic [1:0]         last_q, last_d;

  logic signed [4:0]  vote;
  logic signed [4:0]  filt_sum;
  logic [1:0]         dir;
  logic               at_limit;

  assign vote = (pd_up && !pd_dn) ? 5'sd1 : ((pd_dn && !pd_up) ? -5'sd1 : 5'sd0);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    lock_d   = lock_q;
    filt_d   = filt_q;
    settle_d = settle_q;
    rev_d    = rev_q;
    last_d   = last_q;
    filt_sum = filt_q + vote;
    dir      = (filt_sum == FILT_P) ? DIR_UP : DIR_DN;
    at_limit = (dir == DIR_UP) ? (code_q == CODE_MAX) : (code_q == 7'd0);

    if (ovr_en) begin
      state_d = ST_IDLE;
      code_d  = (ovr_code > CODE_MAX) ? CODE_MAX : ovr_code;
      lock_d  = 1'b0;
      filt_d  = '0;
      rev_d   = '0;
    end else if (!en) begin
      state_d = ST_IDLE;
      lock_d  = 1'b0;
      filt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_W;
          filt_d   = '0;
        end
        ST_SETTLE: begin
          settle_d = settle_q - 5'd1;
          if (settle_q == 5'd1) state_d = lock_q ? ST_LOCKED : ST_TRACK;
        end
        default: begin
          if (filt_sum == FILT_P || filt_sum == FILT_N) begin
            filt_d = '0;
            // A step into a limit is dropped entirely: no settle, no history.
            if (!at_limit) begin
              code_d   = (dir == DIR_UP) ? code_q + 7'd1 : code_q - 7'd1;
              state_d  = ST_SETTLE;
              settle_d = SETTLE_W;
              last_d   = dir;
              if (last_q != DIR_NONE && last_q != dir) begin
                rev_d = (rev_q == REV_MAX) ? rev_q : rev_q + 3'd1;
                if (rev_d == REV_MAX) lock_d = 1'b1;
              end else begin
                rev_d  = '0;
                lock_d = 1'b0;
              end
            end
          end else begin
            filt_d = filt_sum;
          end
        end
      endcase
    end
  end

  // bk is registered from the next code so both move on the same edge.
  for (genvar gi = 0; gi < 64; gi++) begin : g_bk
    assign bk_d[gi] = (code_d > 7'(gi));
  end

  always_ff @(posedge CLKIN or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      code_q   <= INIT_W;
      bk_q     <= BK_INIT;
      lock_q   <= 1'b0;
      filt_q   <= '0;
      settle_q <= '0;
      rev_q    <= '0;
      last_q   <= DIR_NONE;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      bk_q     <= bk_d;
      lock_q   <= lock_d;
      filt_q   <= filt_d;
      settle_q <= settle_d;
      rev_q    <= rev_d;
      last_q   <= last_d;
    end
  end

  assign code   = code_q;
  assign bk     = bk_q;
  assign lock   = lock_q;
  assign at_min = (code_q == 7'd0);
  assign at_max = (code_q == CODE_MAX);

endmodule

// File: doc/aibcr3_dll_dlyctrl64.md
AIBCR3_DLL_DLYCTRL64 -- requirements
Module: aibcr3_dll_dlyctrl64

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4: net same-direction pd votes required per code step (range 1..15).
REQ-002 SHALL have parameter SETTLE, default 8: CLKIN cycles ignored after any code change (range 1..31).
REQ-003 SHALL have parameter LOCK_DITHER, default 3: consecutive direction reversals required to declare lock (range 1..7).
REQ-004 SHALL have parameter INIT_CODE, default 32: code value after reset (range 0..64).
REQ-005 SHALL have port CLKIN, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port RSTb, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: tracking enable.
REQ-008 SHALL have port pd_up, input, 1 bit: phase-detector vote to lengthen delay, synchronous to CLKIN.
REQ-009 SHALL have port pd_dn, input, 1 bit: phase-detector vote to shorten delay, synchronous to CLKIN.
REQ-010 SHALL have port ovr_en, input, 1 bit: forces code to ovr_code.
REQ-011 SHALL have port ovr_code, input, 7 bits: override code; values above 64 clip to 64.
REQ-012 SHALL have port bk, output, 64 bits: thermometer select to the 64-cell delay line.
REQ-013 SHALL have port code, output, 7 bits: current binary code, 0..64.
REQ-014 SHALL have port lock, output, 1 bit: dither lock indicator.
REQ-015 SHALL have ports at_min and at_max, output, 1 bit each: code==0, code==64.

Function
REQ-016 SHALL register bk with bk[i]=1 exactly for i<code, so bk changes in the same cycle as code and never holds a non-thermometer value.
REQ-017 SHALL implement states IDLE, SETTLE, TRACK, LOCKED.
REQ-018 SHALL hold the code in IDLE, with lock=0 and the filter cleared; en=1 and ovr_en=0 SHALL move IDLE to SETTLE with the settle counter loaded to SETTLE.
REQ-019 SHALL decrement the settle counter once per cycle in SETTLE, ignore pd inputs, and enter TRACK (or LOCKED when lock=1) when the counter reaches 0.
REQ-020 SHALL use a signed filter (range -FILT_LEN..+FILT_LEN) in TRACK and LOCKED: +1 on pd_up&!pd_dn, -1 on pd_dn&!pd_up, unchanged on both-high or both-low.
REQ-021 SHALL step the code by +1 (filter reaching +FILT_LEN) or -1 (reaching -FILT_LEN) in the same cycle, clear the filter, and enter SETTLE.
REQ-022 SHALL saturate at the limits: a step past 64 or below 0 SHALL leave code unchanged, clear the filter, not enter SETTLE, not count as a step for lock purposes, and keep at_max/at_min asserted.
REQ-023 SHALL record the direction of each non-saturated step; a step opposite to the previous one SHALL increment the reversal counter, and a same-direction step SHALL clear it.
REQ-024 SHALL set lock=1 when the reversal counter reaches LOCK_DITHER, and the state SHALL then be LOCKED.
REQ-025 SHALL, in LOCKED, keep tracking identically; two consecutive same-direction steps SHALL clear lock and the reversal counter and return to TRACK via SETTLE.
REQ-026 SHALL, on ovr_en=1 in any state, load code=min(ovr_code,64) on the next edge, clear lock, the filter and the reversal counter, and hold IDLE.
REQ-027 SHALL, when ovr_en falls with en=1, enter SETTLE from the override code.
REQ-028 SHALL, on en=0 (ovr_en=0), return to IDLE on the next edge, hold the code, and clear lock.
REQ-029 SHALL have a latency of 1 cycle from the filter-completing vote to the code/bk update.

Reset
REQ-030 SHALL, on RSTb=0, immediately set code=INIT_CODE, bk=thermometer(INIT_CODE), lock=0, state IDLE, and clear the filter, settle counter, reversal counter and last direction; at_min/at_max SHALL follow the code.
REQ-031 SHALL abort any in-progress settle or filter accumulation when reset is asserted mid-operation; release SHALL be synchronized to CLKIN before the first state update.

Verification
REQ-032 Bench SHALL cover: reset then en=1, pd_up held high -> after 8 settle cycles, code 32->33 on the 4th up vote, bk[32]=1, then a further 8-cycle settle gap.
REQ-033 Bench SHALL cover: alternating 4-up/4-down vote bursts -> lock=1 after the 3rd reversal, code dithering 32/33; then two consecutive up steps -> lock=0.
REQ-034 Bench SHALL cover: ovr_code=100 with ovr_en=1 -> code=64, bk=all ones, at_max=1; sustained pd_up after release -> code stays 64 with no settle entry.
REQ-035 Bench SHALL cover: pd_up=pd_dn=1 for 50 cycles in TRACK -> code and filter unchanged.
REQ-036 Bench SHALL cover: RSTb pulsed low mid-SETTLE at code 40 -> code=32 and lock=0 immediately, asynchronously.
REQ-037 Bench SHALL cover: en dropped in LOCKED at code 20 -> IDLE, code held at 20, lock=0 next cycle.
